q_deser: RTL

Serial-to-parallel collector on the downstream side of the single-bit D flip-flop. It samples the flop's Q stream one qualified bit at a time and assembles WIDTH-bit words. Each word is presented to the next stage through a one-deep valid/ready holding register. Overflow is reported with a sticky flag.

---
 rtl/q_deser_pkg.sv | 21 ++
 rtl/q_deser_hold.sv | 58 +++++
 rtl/q_deser.sv | 136 +++++++++++++
 3 files changed

// File: rtl/q_deser_pkg.sv
// Shared types and helpers for the q_deser serial-to-parallel collector.
// Optional parity support is selected with the Q_DESER_PARITY_EN macro.
package q_deser_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } state_e;

  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  // 1 when data bits plus the even-parity bit do not XOR to zero
  function automatic logic even_par_err(input logic [MAX_WIDTH-1:0] data, input logic pbit);
    return (^data) ^ pbit;
  endfunction

endpackage

// File: rtl/q_deser_hold.sv
// One-deep valid/ready holding register between the collector and its consumer.
// A load while full and not draining is dropped and flagged on drop_o.
module q_deser_hold #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             par_err_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] word_o,
  output logic             valid_o,
  output logic             par_err_o,
  output logic             drop_o
);

  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             par_err_q, par_err_d;
  logic             accept_s;

  // Holding register state
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q    <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      word_q    <= word_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
    end
  end

  // Load when empty or draining on this same edge; otherwise the new word is lost
  always_comb begin
    accept_s  = load_i && (!valid_q || ready_i);
    drop_o    = load_i && valid_q && !ready_i;
    word_d    = word_q;
    par_err_d = par_err_q;
    valid_d   = valid_q;
    if (accept_s) begin
      word_d    = data_i;
      par_err_d = par_err_i;
      valid_d   = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d   = 1'b0;
    end else begin
      valid_d   = valid_q;
    end
  end

  assign word_o    = word_q;
  assign valid_o   = valid_q;
  assign par_err_o = par_err_q;

endmodule

// File: rtl/q_deser.sv
// Collects qualified serial bits LSB-first into WIDTH-bit words with sticky overrun.
// Define Q_DESER_PARITY_EN to expect a trailing even-parity bit after each word.
module q_deser #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             D,
  input  logic             D_VALID,
  output logic [WIDTH-1:0] WORD,
  output logic             WORD_VALID,
  input  logic             WORD_READY,
  output logic             OVERRUN,
  output logic             PARITY_ERR
);
  import q_deser_pkg::*;

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             overrun_q, overrun_d;
  logic             load_s;
  logic [WIDTH-1:0] load_data_s;
  logic             par_err_s;
  logic             drop_s;

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: only accepted bits advance the FSM
  always_comb begin
    state_d = state_q;
    if (D_VALID) begin
      case (state_q)
        COLLECT: begin
`ifdef Q_DESER_PARITY_EN
          if (cnt_q == LAST) begin
            state_d = PARITY;
          end else begin
            state_d = COLLECT;
          end
`else
          state_d = COLLECT;
`endif
        end
`ifdef Q_DESER_PARITY_EN
        PARITY:  state_d = COLLECT;
`endif
        default: state_d = COLLECT;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Collection datapath and completion strobe
  always_comb begin
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    load_s      = 1'b0;
    load_data_s = shift_q;
    par_err_s   = 1'b0;
    if (D_VALID) begin
      case (state_q)
        COLLECT: begin
          shift_d[cnt_q] = D;
          if (cnt_q == LAST) begin
            cnt_d = '0;
`ifndef Q_DESER_PARITY_EN
            load_s      = 1'b1;
            load_data_s = shift_d;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef Q_DESER_PARITY_EN
        PARITY: begin
          load_s      = 1'b1;
          load_data_s = shift_q;
          par_err_s   = even_par_err(MAX_WIDTH'(shift_q), D);
        end
`endif
        default: begin
          cnt_d = '0;
        end
      endcase
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Collection registers and sticky overrun
  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    overrun_d = overrun_q | drop_s;
  end

  q_deser_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk       (CLK),
    .rst       (RST),
    .load_i    (load_s),
    .data_i    (load_data_s),
    .par_err_i (par_err_s),
    .ready_i   (WORD_READY),
    .word_o    (WORD),
    .valid_o   (WORD_VALID),
    .par_err_o (PARITY_ERR),
    .drop_o    (drop_s)
  );

  assign OVERRUN = overrun_q;

endmodule
